// File: rtl/llr_ram_sequencer.sv
// LLR RAM sequencer: LOAD writes a valid/ready stream to addresses 0..len-1; READ replays them through a 2-entry skid FIFO; optional CLEAR via LLR_RAM_SEQ_CLEAR_EN.
// Read latency: first out_valid 2 cycles after READ entry, 1 word/cycle sustained; out_ready low stalls RAM reads once FIFO plus in-flight would exceed 2.
module llr_ram_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   block_len,
    input  logic                  load_start,
    input  logic                  read_start,
`ifdef LLR_RAM_SEQ_CLEAR_EN
    input  logic                  clear_start,
    output logic                  clear_done,
`endif
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  load_done,
    output logic                  read_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_we,
    output logic                  ram_cs
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN
`ifdef LLR_RAM_SEQ_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   r_len;
    logic                  r_in_flight;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_load_done;
    logic                  r_read_done;
`ifdef LLR_RAM_SEQ_CLEAR_EN
    logic                  r_clear_done;
    logic                  w_clr;
`endif

    logic [ADDR_WIDTH:0]   w_len_clip;
    logic [ADDR_WIDTH:0]   w_cnt_inc;
    logic                  w_wr;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_room;
    logic                  w_rd;

    assign w_len_clip = (block_len > LP_DEPTH) ? LP_DEPTH : block_len;
    assign w_cnt_inc  = r_cnt + LP_ONE;
    assign w_wr       = (r_state == S_LOAD) && in_valid;
    assign w_pop      = (r_count != 2'd0) && out_ready;
    // Occupancy counts words already buffered plus the one returning from RAM.
    assign w_occ      = {1'b0, r_count} + {2'b00, r_in_flight};
    assign w_room     = (w_occ <= 3'd1) || ((w_occ == 3'd2) && w_pop);
    assign w_rd       = (r_state == S_READ) && (r_cnt < r_len) && w_room;
`ifdef LLR_RAM_SEQ_CLEAR_EN
    assign w_clr      = (r_state == S_CLEAR);
    assign clear_done = r_clear_done;
`endif

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo[r_rd_ptr];
    assign load_done = r_load_done;
    assign read_done = r_read_done;

    always_comb begin
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        if (w_wr) begin
            ram_cs      = 1'b1;
            ram_we      = 1'b1;
            ram_address = r_cnt[ADDR_WIDTH-1:0];
            ram_data_in = in_data;
        end else if (w_rd) begin
            ram_cs      = 1'b1;
            ram_address = r_cnt[ADDR_WIDTH-1:0];
        end
`ifdef LLR_RAM_SEQ_CLEAR_EN
        else if (w_clr) begin
            ram_cs      = 1'b1;
            ram_we      = 1'b1;
            ram_address = r_cnt[ADDR_WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_in_flight  <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_load_done  <= 1'b0;
            r_read_done  <= 1'b0;
`ifdef LLR_RAM_SEQ_CLEAR_EN
            r_clear_done <= 1'b0;
`endif
        end else begin
            r_load_done  <= 1'b0;
            r_read_done  <= 1'b0;
`ifdef LLR_RAM_SEQ_CLEAR_EN
            r_clear_done <= 1'b0;
`endif
            if (r_in_flight) begin
                r_fifo[r_wr_ptr] <= ram_data_out;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count     <= r_count + {1'b0, r_in_flight} - {1'b0, w_pop};
            r_in_flight <= w_rd;

            case (r_state)
                S_IDLE: begin
`ifdef LLR_RAM_SEQ_CLEAR_EN
                    if (clear_start) begin
                        r_cnt   <= '0;
                        r_state <= S_CLEAR;
                    end else
`endif
                    if (load_start) begin
                        r_cnt <= '0;
                        r_len <= w_len_clip;
                        if (w_len_clip == '0) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else if (read_start) begin
                        r_cnt <= '0;
                        r_len <= w_len_clip;
                        if (w_len_clip == '0) begin
                            r_read_done <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_wr) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_state     <= S_IDLE;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_count == 2'd0) && !r_in_flight) begin
                        r_state     <= S_IDLE;
                        r_read_done <= 1'b1;
                    end
                end
`ifdef LLR_RAM_SEQ_CLEAR_EN
                S_CLEAR: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == (LP_DEPTH - LP_ONE)) begin
                        r_state      <= S_IDLE;
                        r_clear_done <= 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
